mastermind_game_ctrl: RTL and testbench

//  Parametrised Mastermind controller: NPEGS-peg secret pattern, NCOLORS colours, MAX_ROUNDS guesses.

---
 rtl/mastermind_game_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mastermind_game_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game controller.
// Holds a write-once secret pattern and grades submitted guesses over NCOLORS cycles
// (one colour per cycle). It tracks rounds and the won/lost result, and performs a
// req/done handshake with a display driver for the start animation and for each
// feedback frame.
//
// Ports:
//   clock, reset       clock; synchronous active-high reset
//   start_game         start a game from LOAD, or restart from OVER
//   load_color         write color_to_load into pattern slot color_location
//   color_to_load      pattern colour code
//   color_location     pattern slot index
//   grade_it           submit guess (accepted in PLAY only)
//   guess              guess pegs, peg i = guess[i*CW +: CW]
//   disp_done          display finished the current request
//   disp_req           display request, held until disp_done
//   disp_mode          0 = start animation, 1 = feedback
//   pattern_ready      every slot of the pattern is loaded
//   busy               grading or waiting on the display
//   round_number       current round, 1..MAX_ROUNDS while playing
//   red, white         counts from the last grade
//   feedback           per slot: 2'b10 red, 2'b01 white, 2'b00 none
//   fb_valid           one-cycle pulse when red/white/feedback change
//   won, lost          game result, held in OVER
module mastermind_game_ctrl #(
  parameter int unsigned NPEGS      = 4,
  parameter int unsigned CW         = 3,
  parameter int unsigned NCOLORS    = 6,
  parameter int unsigned MAX_ROUNDS = 10,
  localparam int unsigned RW = $clog2(MAX_ROUNDS + 1),
  localparam int unsigned NW = $clog2(NPEGS + 1),
  localparam int unsigned LW = $clog2(NPEGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_game,
  input  logic                  load_color,
  input  logic [CW-1:0]         color_to_load,
  input  logic [LW-1:0]         color_location,
  input  logic                  grade_it,
  input  logic [NPEGS*CW-1:0]   guess,
  input  logic                  disp_done,
  output logic                  disp_req,
  output logic                  disp_mode,
  output logic                  pattern_ready,
  output logic                  busy,
  output logic [RW-1:0]         round_number,
  output logic [NW-1:0]         red,
  output logic [NW-1:0]         white,
  output logic [NPEGS*2-1:0]    feedback,
  output logic                  fb_valid,
  output logic                  won,
  output logic                  lost
);

  localparam logic [2:0] StLoad   = 3'd0;
  localparam logic [2:0] StStartD = 3'd1;
  localparam logic [2:0] StPlay   = 3'd2;
  localparam logic [2:0] StGrade  = 3'd3;
  localparam logic [2:0] StShowD  = 3'd4;
  localparam logic [2:0] StOver   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      pattern_q [NPEGS];
  logic [CW-1:0]      guess_q [NPEGS];
  logic [NPEGS-1:0]   loaded_q;
  logic [CW-1:0]      color_idx_q;
  logic [NW-1:0]      acc_q;
  logic [RW-1:0]      round_q;
  logic [NW-1:0]      red_q, white_q;
  logic [NPEGS*2-1:0] feedback_q;
  logic               fb_valid_q, won_q, lost_q;

  logic               load_ok, grade_last;
  logic [NW-1:0]      red_c, gcnt_c, pcnt_c, min_c, match_c, white_c;
  logic [NPEGS*2-1:0] fb_c;

  assign load_ok = load_color && (32'(color_to_load) < NCOLORS) &&
                   (32'(color_location) < NPEGS) && !loaded_q[color_location];
  assign grade_last = (color_idx_q == CW'(NCOLORS - 1));

  // Exact matches, per-colour histograms for the current colour, and running match total.
  always_comb begin
    red_c  = '0;
    gcnt_c = '0;
    pcnt_c = '0;
    for (int unsigned i = 0; i < NPEGS; i++) begin
      if (guess_q[i] == pattern_q[i]) red_c = red_c + NW'(1);
      if (guess_q[i] == color_idx_q) gcnt_c = gcnt_c + NW'(1);
      if (pattern_q[i] == color_idx_q) pcnt_c = pcnt_c + NW'(1);
    end
    min_c   = (gcnt_c < pcnt_c) ? gcnt_c : pcnt_c;
    match_c = acc_q + min_c;
    white_c = match_c - red_c;
  end

  // Reds fill the low slots, whites follow; match_c is red + white.
  always_comb begin
    fb_c = '0;
    for (int unsigned k = 0; k < NPEGS; k++) begin
      if (NW'(k) < red_c) fb_c[2*k +: 2] = 2'b10;
      else if (NW'(k) < match_c) fb_c[2*k +: 2] = 2'b01;
      else fb_c[2*k +: 2] = 2'b00;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StLoad:   if (start_game && pattern_ready) state_d = StStartD;
      StStartD: if (disp_done) state_d = StPlay;
      StPlay:   if (grade_it) state_d = StGrade;
      StGrade:  if (grade_last) state_d = StShowD;
      StShowD:  if (disp_done) state_d = (won_q || lost_q) ? StOver : StPlay;
      StOver:   if (start_game) state_d = StLoad;
      default:  state_d = StLoad;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StLoad;
      loaded_q    <= '0;
      color_idx_q <= '0;
      acc_q       <= '0;
      round_q     <= '0;
      red_q       <= '0;
      white_q     <= '0;
      feedback_q  <= '0;
      fb_valid_q  <= 1'b0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
      for (int unsigned i = 0; i < NPEGS; i++) begin
        pattern_q[i] <= '0;
        guess_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fb_valid_q <= 1'b0;
      case (state_q)
        StLoad: begin
          if (load_ok) begin
            pattern_q[color_location] <= color_to_load;
            loaded_q[color_location]  <= 1'b1;
          end
          if (start_game && pattern_ready) begin
            round_q <= RW'(1);
            won_q   <= 1'b0;
            lost_q  <= 1'b0;
          end
        end
        StPlay: begin
          if (grade_it) begin
            for (int unsigned i = 0; i < NPEGS; i++) guess_q[i] <= guess[i*CW +: CW];
            color_idx_q <= '0;
            acc_q       <= '0;
          end
        end
        StGrade: begin
          if (grade_last) begin
            red_q      <= red_c;
            white_q    <= white_c;
            feedback_q <= fb_c;
            fb_valid_q <= 1'b1;
            if (red_c == NW'(NPEGS)) won_q <= 1'b1;
            else if (round_q == RW'(MAX_ROUNDS)) lost_q <= 1'b1;
            else round_q <= round_q + RW'(1);
          end else begin
            color_idx_q <= color_idx_q + CW'(1);
            acc_q       <= match_c;
          end
        end
        StOver: begin
          if (start_game) begin
            loaded_q <= '0;
            round_q  <= '0;
            won_q    <= 1'b0;
            lost_q   <= 1'b0;
            for (int unsigned i = 0; i < NPEGS; i++) pattern_q[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign disp_req      = (state_q == StStartD) || (state_q == StShowD);
  assign disp_mode     = (state_q == StShowD);
  assign busy          = (state_q == StGrade) || disp_req;
  assign pattern_ready = &loaded_q;
  assign round_number  = round_q;
  assign red           = red_q;
  assign white         = white_q;
  assign feedback      = feedback_q;
  assign fb_valid      = fb_valid_q;
  assign won           = won_q;
  assign lost          = lost_q;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Self-checking bench for mastermind_game_ctrl: directed scenarios plus random games,
// checked against a histogram-based scoring model of the game rules.
module tb_mastermind_game_ctrl;
  localparam int NPEGS = 4, CW = 3, NCOLORS = 6, MAX_ROUNDS = 10;
  localparam int RW = $clog2(MAX_ROUNDS + 1), NW = $clog2(NPEGS + 1), LW = $clog2(NPEGS);
  localparam int GW = NPEGS * CW;
  typedef int peg_arr_t [NPEGS];

  logic clock = 1'b0, reset = 1'b1;
  logic start_game = 1'b0, load_color = 1'b0, grade_it = 1'b0, disp_done = 1'b0;
  logic [CW-1:0] color_to_load = '0;
  logic [LW-1:0] color_location = '0;
  logic [GW-1:0] guess = '0;
  logic disp_req, disp_mode, pattern_ready, busy, fb_valid, won, lost;
  logic [RW-1:0] round_number;
  logic [NW-1:0] red, white;
  logic [NPEGS*2-1:0] feedback;

  int checks = 0, errors = 0;
  int pat[NPEGS];
  bit ldd[NPEGS];
  int m_round;
  bit m_won, m_lost;

  mastermind_game_ctrl #(.NPEGS(NPEGS), .CW(CW), .NCOLORS(NCOLORS), .MAX_ROUNDS(MAX_ROUNDS)) dut (
    .clock(clock), .reset(reset), .start_game(start_game), .load_color(load_color),
    .color_to_load(color_to_load), .color_location(color_location), .grade_it(grade_it),
    .guess(guess), .disp_done(disp_done), .disp_req(disp_req), .disp_mode(disp_mode),
    .pattern_ready(pattern_ready), .busy(busy), .round_number(round_number), .red(red),
    .white(white), .feedback(feedback), .fb_valid(fb_valid), .won(won), .lost(lost)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  function automatic bit all_loaded();
    for (int i = 0; i < NPEGS; i++) if (!ldd[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NPEGS; i++) begin ldd[i] = 1'b0; pat[i] = 0; end
    m_round = 0; m_won = 1'b0; m_lost = 1'b0;
  endtask

  task automatic load_slot(input int loc, input int col);
    color_location = LW'(loc); color_to_load = CW'(col); load_color = 1'b1;
    tick(); load_color = 1'b0;
    if (col < NCOLORS && !ldd[loc]) begin pat[loc] = col; ldd[loc] = 1'b1; end
  endtask

  task automatic load_random();
    for (int it = 0; it < 200 && !all_loaded(); it++) begin
      load_slot($urandom_range(0, NPEGS - 1), $urandom_range(0, (1 << CW) - 1));
      checks++;
      if (pattern_ready !== all_loaded()) begin
        $display("FAIL rand_load_ready: got %b want %b", pattern_ready, all_loaded());
        errors++;
      end
    end
    for (int i = 0; i < NPEGS; i++) if (!ldd[i]) load_slot(i, $urandom_range(0, NCOLORS - 1));
  endtask

  task automatic restart();
    start_game = 1'b1; tick(); start_game = 1'b0;
    clear_model();
  endtask

  task automatic begin_game(input int dly);
    start_game = 1'b1; tick(); start_game = 1'b0;
    m_round = 1; m_won = 1'b0; m_lost = 1'b0;
    checks++;
    if (disp_req !== 1'b1 || disp_mode !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL start_req: req=%b mode=%b busy=%b want 1 0 1", disp_req, disp_mode, busy);
      errors++;
    end
    tick(dly);
    checks++;
    if (disp_req !== 1'b1 || round_number !== RW'(1) || won !== 1'b0 || lost !== 1'b0) begin
      $display("FAIL start_hold: req=%b round=%0d won=%b lost=%b want 1 1 0 0",
               disp_req, round_number, won, lost);
      errors++;
    end
    disp_done = 1'b1; tick(); disp_done = 1'b0;
    checks++;
    if (disp_req !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL start_done: req=%b busy=%b want 0 0", disp_req, busy);
      errors++;
    end
  endtask

  // Submit one guess; scoring expectations come from colour histograms of the rules.
  task automatic play_guess(input peg_arr_t g, input int dly);
    int r, m, w, n;
    int hp[NCOLORS];
    int hg[NCOLORS];
    logic [NPEGS*2-1:0] fb;
    r = 0; m = 0;
    for (int c = 0; c < NCOLORS; c++) begin hp[c] = 0; hg[c] = 0; end
    for (int i = 0; i < NPEGS; i++) begin
      if (g[i] == pat[i]) r++;
      hp[pat[i]]++; hg[g[i]]++;
      guess[i*CW +: CW] = CW'(g[i]);
    end
    for (int c = 0; c < NCOLORS; c++) m += (hp[c] < hg[c]) ? hp[c] : hg[c];
    w = m - r;
    for (int k = 0; k < NPEGS; k++) fb[2*k +: 2] = (k < r) ? 2'b10 : ((k < m) ? 2'b01 : 2'b00);
    if (r == NPEGS) m_won = 1'b1;
    else if (m_round == MAX_ROUNDS) m_lost = 1'b1;
    else m_round++;

    grade_it = 1'b1; tick(); grade_it = 1'b0;
    guess = GW'($urandom);
    disp_done = 1'b1; tick(); disp_done = 1'b0; // done outside a display state is ignored
    n = 2;
    while (fb_valid !== 1'b1 && n < 3 * NCOLORS) begin tick(); n++; end
    checks++;
    if (n !== NCOLORS + 1) begin
      $display("FAIL grade_latency: got %0d cycles want %0d", n, NCOLORS + 1);
      errors++;
    end
    checks++;
    if (red !== NW'(r) || white !== NW'(w) || feedback !== fb) begin
      $display("FAIL grade_score: red=%0d white=%0d fb=%b want %0d %0d %b",
               red, white, feedback, r, w, fb);
      errors++;
    end
    checks++;
    if (won !== m_won || lost !== m_lost || round_number !== RW'(m_round)) begin
      $display("FAIL grade_result: won=%b lost=%b round=%0d want %b %b %0d",
               won, lost, round_number, m_won, m_lost, m_round);
      errors++;
    end
    checks++;
    if (disp_req !== 1'b1 || disp_mode !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL show_req: req=%b mode=%b busy=%b want 1 1 1", disp_req, disp_mode, busy);
      errors++;
    end
    tick();
    checks++;
    if (fb_valid !== 1'b0 || disp_req !== 1'b1) begin
      $display("FAIL fb_pulse: fb_valid=%b req=%b want 0 1", fb_valid, disp_req);
      errors++;
    end
    grade_it = 1'b1; tick(dly); grade_it = 1'b0; // grade level during display is ignored
    disp_done = 1'b1; tick(); disp_done = 1'b0;
    checks++;
    if (disp_req !== 1'b0 || busy !== 1'b0 || fb_valid !== 1'b0) begin
      $display("FAIL show_done: req=%b busy=%b fb_valid=%b want 0 0 0", disp_req, busy, fb_valid);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(2); reset = 1'b0; clear_model();
    checks++;
    if ({disp_req, disp_mode, pattern_ready, busy, fb_valid, won, lost} !== 7'b0 ||
        round_number !== '0 || red !== '0 || white !== '0 || feedback !== '0) begin
      $display("FAIL reset_outputs: req=%b mode=%b rdy=%b busy=%b fbv=%b won=%b lost=%b round=%0d red=%0d white=%0d fb=%b want all 0",
               disp_req, disp_mode, pattern_ready, busy, fb_valid, won, lost, round_number,
               red, white, feedback);
      errors++;
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < NPEGS - 1; i++) begin
      load_slot(i, i);
      checks++;
      if (pattern_ready !== 1'b0) begin
        $display("FAIL load_partial: ready=%b want 0 after slot %0d", pattern_ready, i);
        errors++;
      end
    end
    load_slot(NPEGS - 1, 6); // illegal colour: slot stays unloaded
    checks++;
    if (pattern_ready !== 1'b0) begin
      $display("FAIL load_illegal: ready=%b want 0", pattern_ready);
      errors++;
    end
    load_slot(NPEGS - 1, NPEGS - 1);
    checks++;
    if (pattern_ready !== 1'b1) begin
      $display("FAIL load_full: ready=%b want 1", pattern_ready);
      errors++;
    end
    load_slot(0, 5); // already loaded: ignored
  endtask

  task automatic test_win();
    peg_arr_t g;
    begin_game(3);
    for (int i = 0; i < NPEGS; i++) g[i] = i;
    play_guess(g, 2);
    checks++;
    if (won !== 1'b1 || lost !== 1'b0 || red !== NW'(4) || feedback !== 8'b10101010) begin
      $display("FAIL win_const: won=%b lost=%b red=%0d fb=%b want 1 0 4 10101010",
               won, lost, red, feedback);
      errors++;
    end
  endtask

  task automatic test_over_restart();
    bit seen;
    seen = 1'b0;
    grade_it = 1'b1;
    for (int i = 0; i < NCOLORS + 3; i++) begin tick(); seen |= (busy | fb_valid | disp_req); end
    grade_it = 1'b0;
    checks++;
    if (seen !== 1'b0 || won !== m_won || lost !== m_lost || round_number !== RW'(m_round)) begin
      $display("FAIL over_hold: activity=%b won=%b lost=%b round=%0d want 0 %b %b %0d",
               seen, won, lost, round_number, m_won, m_lost, m_round);
      errors++;
    end
    restart();
    checks++;
    if (won !== 1'b0 || lost !== 1'b0 || round_number !== '0 || pattern_ready !== 1'b0) begin
      $display("FAIL restart_clear: won=%b lost=%b round=%0d ready=%b want 0 0 0 0",
               won, lost, round_number, pattern_ready);
      errors++;
    end
    grade_it = 1'b1; start_game = 1'b1; seen = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); seen |= (busy | fb_valid | disp_req); end
    grade_it = 1'b0; start_game = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      $display("FAIL load_ignore: activity=%b want 0", seen);
      errors++;
    end
  endtask

  task automatic test_white_swap();
    peg_arr_t g;
    for (int i = 0; i < NPEGS; i++) load_slot(i, NPEGS - 1 - i);
    begin_game(0);
    for (int i = 0; i < NPEGS; i++) g[i] = i;
    play_guess(g, 1);
    checks++;
    if (red !== '0 || white !== NW'(4) || feedback !== 8'b01010101 || round_number !== RW'(2)) begin
      $display("FAIL swap_const: red=%0d white=%0d fb=%b round=%0d want 0 4 01010101 2",
               red, white, feedback, round_number);
      errors++;
    end
    play_guess(pat, 0);
  endtask

  task automatic test_dup_and_lose();
    peg_arr_t g;
    restart();
    load_slot(0, 1); load_slot(1, 1); load_slot(2, 2); load_slot(3, 2);
    begin_game(1);
    g[0] = 1; g[1] = 2; g[2] = 1; g[3] = 3;
    play_guess(g, 0);
    checks++;
    if (red !== NW'(1) || white !== NW'(2) || feedback !== 8'b00010110) begin
      $display("FAIL dup_const: red=%0d white=%0d fb=%b want 1 2 00010110", red, white, feedback);
      errors++;
    end
    for (int t = 1; t < MAX_ROUNDS; t++) begin
      bit same;
      same = 1'b1;
      for (int i = 0; i < NPEGS; i++) begin
        g[i] = $urandom_range(0, NCOLORS - 1);
        if (g[i] != pat[i]) same = 1'b0;
      end
      if (same) g[0] = (g[0] + 1) % NCOLORS;
      play_guess(g, $urandom_range(0, 3));
    end
    checks++;
    if (lost !== 1'b1 || won !== 1'b0 || round_number !== RW'(MAX_ROUNDS)) begin
      $display("FAIL lose_final: lost=%b won=%b round=%0d want 1 0 %0d",
               lost, won, round_number, MAX_ROUNDS);
      errors++;
    end
  endtask

  task automatic test_random_games();
    peg_arr_t g;
    for (int gm = 0; gm < 4; gm++) begin
      restart();
      load_random();
      begin_game($urandom_range(0, 4));
      while (!m_won && !m_lost) begin
        for (int i = 0; i < NPEGS; i++) g[i] = $urandom_range(0, NCOLORS - 1);
        if ($urandom_range(0, 5) == 0) g = pat;
        play_guess(g, $urandom_range(0, 3));
      end
    end
  endtask

  task automatic test_reset_mid();
    peg_arr_t g;
    restart();
    load_random();
    begin_game(1);
    for (int i = 0; i < NPEGS; i++) g[i] = $urandom_range(0, NCOLORS - 1);
    for (int i = 0; i < NPEGS; i++) guess[i*CW +: CW] = CW'(g[i]);
    grade_it = 1'b1; tick(); grade_it = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0; clear_model();
    checks++;
    if ({disp_req, disp_mode, pattern_ready, busy, fb_valid, won, lost} !== 7'b0 ||
        round_number !== '0 || red !== '0 || white !== '0 || feedback !== '0) begin
      $display("FAIL reset_mid_grade: req=%b busy=%b rdy=%b fbv=%b won=%b lost=%b round=%0d red=%0d white=%0d fb=%b want all 0",
               disp_req, busy, pattern_ready, fb_valid, won, lost, round_number, red, white,
               feedback);
      errors++;
    end
    for (int i = 0; i < NPEGS; i++) load_slot(i, $urandom_range(0, NCOLORS - 1));
    start_game = 1'b1; tick(); start_game = 1'b0;
    checks++;
    if (disp_req !== 1'b1 || disp_mode !== 1'b0) begin
      $display("FAIL reset_to_load: req=%b mode=%b want 1 0", disp_req, disp_mode);
      errors++;
    end
    reset = 1'b1; tick(); reset = 1'b0; clear_model();
    checks++;
    if (disp_req !== 1'b0 || busy !== 1'b0 || round_number !== '0) begin
      $display("FAIL reset_mid_disp: req=%b busy=%b round=%0d want 0 0 0",
               disp_req, busy, round_number);
      errors++;
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_load();
    test_win();
    test_over_restart();
    test_white_swap();
    test_dup_and_lose();
    test_over_restart();
    test_random_games();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
